// File: rtl/gate_bist.sv
// gate_bist: self-test sequencer for a two-input AND gate. It drives the vectors 00, 01, 10, 11
// and records mismatches. Defining GATE_BIST_FAIL_LOG_EN enables the per-vector fail_vec log.
module gate_bist #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // SETTLE exits when the counter reaches zero, so it is loaded with one less than the hold time.
    localparam logic [3:0] SETTLE_INIT = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       mismatch_s;
`ifdef GATE_BIST_FAIL_LOG_EN
    logic [3:0] fail_q, fail_d;
`endif

    assign mismatch_s = (y != (a_q & b_q));

    // Next-state logic; every output is registered from the state being entered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pass_d  = pass_q;
`ifdef GATE_BIST_FAIL_LOG_EN
        fail_d  = fail_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = APPLY;
                    idx_d   = 2'd0;
                    err_d   = 3'd0;
                    pass_d  = 1'b0;
`ifdef GATE_BIST_FAIL_LOG_EN
                    fail_d  = 4'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            APPLY: begin
                if (SETTLE_CYCLES == 0) begin
                    state_d = SAMPLE;
                end else begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_INIT;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                // At most four vectors are sampled per pass, so err_count cannot wrap.
                if (mismatch_s) begin
                    err_d = err_q + 3'd1;
`ifdef GATE_BIST_FAIL_LOG_EN
                    fail_d[idx_q] = 1'b1;
`endif
                end else begin
                    err_d = err_q;
                end
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                    pass_d  = (err_d == 3'd0);
                end else begin
                    state_d = APPLY;
                    idx_d   = idx_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == APPLY) || (state_d == SETTLE) || (state_d == SAMPLE);
        a_d    = busy_d & idx_d[1];
        b_d    = busy_d & idx_d[0];
        done_d = (state_d == DONE);
    end

    // State and output registers; reset clears everything without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            err_q   <= 3'd0;
            pass_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GATE_BIST_FAIL_LOG_EN
            fail_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef GATE_BIST_FAIL_LOG_EN
            fail_q  <= fail_d;
`endif
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
`ifdef GATE_BIST_FAIL_LOG_EN
    assign fail_vec  = fail_q;
`else
    assign fail_vec  = 4'b0000;
`endif

endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: directed bench for gate_bist with a scoreboard of expected pass results,
// plus a second instance built with SETTLE_CYCLES=0.
module tb_gate_bist;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       y;
    logic       a, b, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;
    int         mode;

    logic       start0, y0, a0, b0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] fail0;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [2:0] err;
        logic [3:0] fv;
        logic       ps;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Gate under test: 0 = AND, 1 = stuck-at-1, 2 = OR.
    assign y  = (mode == 0) ? (a & b) : ((mode == 1) ? 1'b1 : (a | b));
    assign y0 = a0 & b0;

    gate_bist #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .y(y), .a(a), .b(b), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
    );

    gate_bist #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .y(y0), .a(a0), .b(b0), .busy(busy0),
        .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fail0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t predict(input int m);
        exp_t e;
        logic ai, bi, yv;
        e = '0;
        for (int v = 0; v < 4; v++) begin
            ai = v[1];
            bi = v[0];
            yv = (m == 0) ? (ai & bi) : ((m == 1) ? 1'b1 : (ai | bi));
            if (yv != (ai & bi)) begin
                e.err = e.err + 3'd1;
`ifdef GATE_BIST_FAIL_LOG_EN
                e.fv[v] = 1'b1;
`endif
            end
        end
        e.ps = (e.err == 3'd0);
        return e;
    endfunction

    task automatic run_pass(input int m, input bit chk_seq);
        exp_t       e;
        int         edges;
        bit         got;
        logic [1:0] seen[$];
        mode = m;
        sb.push_back(predict(m));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        got   = 1'b0;
        while (!got && edges < 100) begin
            if (busy) seen.push_back({a, b});
            @(posedge clk);
            #1;
            edges++;
            if (done) got = 1'b1;
        end
        check("done_seen", got, 1);
        check("done_edge", edges, 4 * (S + 2) + 1);
        check("busy_in_done", busy, 0);
        e = sb.pop_front();
        check("err_count", err_count, e.err);
        check("fail_vec", fail_vec, e.fv);
        check("pass", pass, e.ps);
        if (chk_seq) begin
            check("seq_len", seen.size(), 4 * (S + 2));
            for (int i = 0; i < seen.size(); i++)
                check("ab_seq", seen[i], i / (S + 2));
        end
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("err_hold", err_count, e.err);
        check("pass_hold", pass, e.ps);
    endtask

    initial begin
        int         edges, dones, bad_falls, first_done, second_done;
        bit         prev_busy, got;
        logic [1:0] seen0[$];

        rst    = 1'b1;
        start  = 1'b0;
        start0 = 1'b0;
        mode   = 0;
        #3;
        check("rst_out", {a, b, busy, done, pass, err_count, fail_vec}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_pass(0, 1'b1);
        run_pass(1, 1'b0);
        run_pass(2, 1'b0);

        // start held high: back-to-back passes, busy may only fall as done rises
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        dones = 0;
        bad_falls   = 0;
        first_done  = 0;
        second_done = 0;
        prev_busy   = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 40) start = 1'b0;
            if (prev_busy && !busy && !done) bad_falls++;
            if (done) begin
                dones++;
                if (dones == 1) first_done = n;
                if (dones == 2) second_done = n;
                check("held_pass", pass, 1);
            end
            prev_busy = busy;
        end
        check("held_dones", dones, 3);
        check("held_bad_falls", bad_falls, 0);
        check("held_first_done", first_done, 17);
        check("held_second_done", second_done, 35);

        // reset in SETTLE of vector 2
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_ab", {busy, a, b}, 3'b110);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out", {a, b, busy, done, pass, err_count, fail_vec}, 0);
        @(negedge clk);
        rst  = 1'b0;
        got  = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) got = 1'b1;
        end
        check("no_done_after_rst", got, 0);
        run_pass(0, 1'b0);

        // SETTLE_CYCLES=0 instance
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        edges  = 1;
        got    = 1'b0;
        while (!got && edges < 100) begin
            if (busy0) seen0.push_back({a0, b0});
            @(posedge clk);
            #1;
            edges++;
            if (done0) got = 1'b1;
        end
        check("s0_done_edge", edges, 9);
        check("s0_pass", pass0, 1);
        check("s0_seq_len", seen0.size(), 8);
        for (int i = 0; i < seen0.size(); i++)
            check("s0_ab_seq", seen0[i], i / 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
- REQ-001 Parameter SETTLE_CYCLES, default 2: number of idle cycles between applying a vector and sampling y; legal range 0..15.
- REQ-002 clk  input  1  rising-edge clock for all state.
- REQ-003 rst  input  1  asynchronous, active-high reset.
- REQ-004 start  input  1  level request to run one self-test pass; sampled only in IDLE.
- REQ-005 y  input  1  output of the two-input AND gate under test.
- REQ-006 a  output  1  registered first operand driven to the gate under test.
- REQ-007 b  output  1  registered second operand driven to the gate under test.
- REQ-008 busy  output  1  high while a pass is in progress (APPLY, SETTLE, SAMPLE).
- REQ-009 done  output  1  one-cycle pulse marking the end of a pass.
- REQ-010 pass  output  1  high when the last completed pass had zero mismatches.
- REQ-011 err_count  output  3  number of mismatching vectors in the last or current pass (0..4).
- REQ-012 fail_vec  output  4  bit k set when vector k mismatched, where k = {a,b}.

Function
- REQ-013 The FSM SHALL have the states IDLE, APPLY, SETTLE, SAMPLE, and DONE.
- REQ-014 IDLE: a=b=0 and busy=0; start=1 at a rising edge moves the FSM to APPLY, sets the 2-bit vector index to 0, and clears err_count, fail_vec, and pass.
- REQ-015 APPLY: lasts one cycle; {a,b} equals the vector index; the next state is SETTLE, or SAMPLE when SETTLE_CYCLES=0.
- REQ-016 SETTLE: {a,b} is held for exactly SETTLE_CYCLES cycles, counted with a 4-bit down-counter; the next state is SAMPLE.
- REQ-017 SAMPLE: lasts one cycle; the block compares y with a&b. On a mismatch, err_count increments and fail_vec[index] is set at the exiting edge.
- REQ-018 On SAMPLE exit, index 3 goes to DONE; any other index increments the index and goes to APPLY.
- REQ-019 Vector order is fixed: 00, 01, 10, 11.
- REQ-020 DONE: lasts one cycle; done=1, a=b=0, and pass=(err_count==0 after the final update); the next state is IDLE.
- REQ-021 Latency: counting the edge that samples start as edge 1, done is high in the cycle following edge 4*(SETTLE_CYCLES+2)+1.
- REQ-022 start is ignored outside IDLE, including in DONE; if start is held high continuously, a new pass begins at the first edge spent in IDLE.
- REQ-023 pass, err_count, and fail_vec hold their values from DONE until the next accepted start.
- REQ-024 err_count cannot overflow; its maximum is 4.
- REQ-025 y is treated as combinationally valid at SAMPLE; the block adds no synchronizer.

Reset
- REQ-026 rst=1 forces state=IDLE, index=0, counter=0, a=b=0, busy=0, done=0, pass=0, err_count=0, and fail_vec=0 immediately, without waiting for a clock edge.
- REQ-027 A reset during a pass aborts it with no done pulse; the first edge after rst deasserts behaves as IDLE.

Configuration
- REQ-028 Macro GATE_BIST_FAIL_LOG_EN: when defined, fail_vec SHALL be registered and updated per REQ-017.
- REQ-029 When GATE_BIST_FAIL_LOG_EN is undefined, the fail_vec port SHALL remain present and be tied to 4'b0000; all other behaviour is unchanged.

Verification (SETTLE_CYCLES=2 and GATE_BIST_FAIL_LOG_EN defined unless stated)
- REQ-030 Correct AND model, one-cycle start pulse -> {a,b} steps 00,01,10,11; done high after edge 17; pass=1; err_count=0; fail_vec=0000.
- REQ-031 y stuck at 1 -> err_count=3, fail_vec=0111, pass=0; with the macro undefined, fail_vec=0000 and err_count=3.
- REQ-032 OR gate substituted for AND -> err_count=2, fail_vec=0110, pass=0.
- REQ-033 start held high for 40 cycles -> busy falls only in the DONE cycle; a second pass starts at the first IDLE edge; exactly one done per pass.
- REQ-034 rst pulsed while index=2 in SETTLE -> all outputs 0 immediately and no done; a following start produces a clean pass=1.
- REQ-035 SETTLE_CYCLES=0 -> done high after edge 9, with each vector held for 2 cycles.
